cia_timer: RTL and testbench

//  16-bit interval timer (TIMER A or TIMER B) consuming cia_control's tctrl_t.

---
 rtl/cia_pkg.sv | 25 ++
 rtl/cia_timer.sv | 86 ++++++++
 tb/tb_cia_timer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cia_pkg.sv
// Shared types and constants for the CIA register bank and its two interval timers.
package cia;

    typedef logic [3:0]  reg4_t;
    typedef logic [7:0]  reg8_t;
    typedef logic [15:0] reg16_t;

    // Per-timer control bits decoded by cia_control from CRA/CRB.
    typedef struct packed {
        logic start;
        logic toggle;
        logic force_load;
        logic count;
    } tctrl_t;

    typedef struct packed {
        reg16_t value;
        logic   ufl;
        logic   pb;
    } timer_out_t;

    localparam reg4_t TA_LO = 4'h4;
    localparam reg4_t TB_LO = 4'h6;

endpackage

// File: rtl/cia_timer.sv
// 16-bit CIA interval timer: latch, down-counter, underflow pulse and PB6/PB7 output.
// All state advances only on the phi2_dn strobe.
module cia_timer
    import cia::*;
#(
    parameter reg4_t ADDR_LO = TA_LO
) (
    input  logic   clk,
    input  logic   res_n,
    input  logic   phi2_dn,
    input  logic   we,
    input  reg4_t  addr,
    input  reg8_t  data,
    input  tctrl_t ctrl,
    output reg16_t value,
    output logic   ufl,
    output logic   pb
);

    localparam reg4_t ADDR_HI = ADDR_LO + 4'd1;

    reg16_t latch_q, latch_d;
    reg16_t counter_q, counter_d;
    logic   cnt_dly_q;
    logic   start_prev_q;
    logic   ufl_q;
    logic   pb_q, pb_d;

    logic wr_lo, wr_hi, load_hi, ufl_next, reload, start_rise;

    always_comb begin
        wr_lo   = we && (addr == ADDR_LO);
        wr_hi   = we && (addr == ADDR_HI);
        load_hi = wr_hi && !ctrl.start;

        // Reload sees this cycle's byte write, so latch_d rather than latch_q.
        latch_d = latch_q;
        if (wr_lo) latch_d[7:0]  = data;
        if (wr_hi) latch_d[15:8] = data;

        ufl_next = cnt_dly_q && (counter_q == 16'h0000);
        reload   = ufl_next | ctrl.force_load | load_hi;

        if (reload)         counter_d = latch_d;
        else if (cnt_dly_q) counter_d = counter_q - 16'd1;
        else                counter_d = counter_q;

        start_rise = ctrl.start && !start_prev_q;
        if (ctrl.toggle) begin
            if (start_rise)    pb_d = 1'b1;
            else if (ufl_next) pb_d = !pb_q;
            else               pb_d = pb_q;
        end else begin
            pb_d = ufl_next;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            latch_q      <= 16'hFFFF;
            counter_q    <= 16'hFFFF;
            cnt_dly_q    <= 1'b0;
            start_prev_q <= 1'b0;
            ufl_q        <= 1'b0;
        end else if (phi2_dn) begin
            latch_q      <= latch_d;
            counter_q    <= counter_d;
            cnt_dly_q    <= ctrl.count;
            start_prev_q <= ctrl.start;
            ufl_q        <= ufl_next;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pb_q <= 1'b0;
        end else if (phi2_dn) begin
            pb_q <= pb_d;
        end
    end

    assign value = counter_q;
    assign ufl   = ufl_q;
    assign pb    = pb_q;

endmodule

// File: tb/tb_cia_timer.sv
// Directed vector bench for cia_timer (TIMER A address map).
module tb_cia_timer;
    import cia::*;

    logic   clk = 1'b0;
    logic   res_n = 1'b0;
    logic   phi2_dn = 1'b0;
    logic   we = 1'b0;
    reg4_t  addr = 4'h0;
    reg8_t  data = 8'h00;
    tctrl_t ctrl = '0;
    reg16_t value;
    logic   ufl;
    logic   pb;

    int n_tests = 0;
    int n_fail  = 0;

    cia_timer #(.ADDR_LO(TA_LO)) dut (
        .clk     (clk),
        .res_n   (res_n),
        .phi2_dn (phi2_dn),
        .we      (we),
        .addr    (addr),
        .data    (data),
        .ctrl    (ctrl),
        .value   (value),
        .ufl     (ufl),
        .pb      (pb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [7:0]  data;
        logic [3:0]  ctl;   // {start, toggle, force_load, count}
        logic [15:0] ev;
        logic        eu;
        logic        ep;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic w, logic [3:0] a, logic [7:0] d, logic [3:0] c,
                               logic [15:0] ev, logic eu, logic ep);
        vec_t r;
        r.we = w; r.addr = a; r.data = d; r.ctl = c;
        r.ev = ev; r.eu = eu; r.ep = ep;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: inputs driven on the falling edge, sampled 1 time unit after the rising edge.
    task automatic cyc(input logic w, input logic [3:0] a, input logic [7:0] d,
                       input logic [3:0] c, input logic strobe);
        @(negedge clk);
        we      = w;
        addr    = a;
        data    = d;
        ctrl    = tctrl_t'(c);
        phi2_dn = strobe;
        @(posedge clk);
        #1;
        phi2_dn = 1'b0;
        we      = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] ev, input logic eu, input logic ep);
        chk({tag, ".value"}, value, ev);
        chk({tag, ".ufl"}, {15'd0, ufl}, {15'd0, eu});
        chk({tag, ".pb"}, {15'd0, pb}, {15'd0, ep});
    endtask

    initial begin
        // Latch 0003, count: period 4 with ufl on the reload cycle.
        vecs.push_back(v(1, 4'h4, 8'h03, 4'b0000, 16'hFFFF, 0, 0));
        vecs.push_back(v(1, 4'h5, 8'h00, 4'b0000, 16'h0003, 0, 0));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h0003, 0, 0));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h0002, 0, 0));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h0001, 0, 0));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h0000, 0, 0));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h0003, 1, 1));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h0002, 0, 0));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h0001, 0, 0));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h0000, 0, 0));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h0003, 1, 1));
        // Delayed count still decrements once after count drops.
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b0000, 16'h0002, 0, 0));
        vecs.push_back(v(1, 4'h4, 8'h00, 4'b0000, 16'h0002, 0, 0));
        vecs.push_back(v(1, 4'h5, 8'h01, 4'b0000, 16'h0100, 0, 0));
        vecs.push_back(v(1, 4'h4, 8'h34, 4'b1000, 16'h0100, 0, 0));
        // High-byte write while started leaves the counter alone.
        vecs.push_back(v(1, 4'h5, 8'h12, 4'b1000, 16'h0100, 0, 0));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h0100, 0, 0));
        // force_load beats the pending decrement.
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1011, 16'h1234, 0, 0));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h1233, 0, 0));
        // High-byte write while stopped reloads at once, over a pending decrement.
        vecs.push_back(v(1, 4'h5, 8'h56, 4'b0000, 16'h5634, 0, 0));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b0000, 16'h5634, 0, 0));
        // Latch 0000: ufl every cycle.
        vecs.push_back(v(1, 4'h4, 8'h00, 4'b0000, 16'h5634, 0, 0));
        vecs.push_back(v(1, 4'h5, 8'h00, 4'b0000, 16'h0000, 0, 0));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h0000, 0, 0));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h0000, 1, 1));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h0000, 1, 1));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h0000, 1, 1));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1011, 16'h0000, 1, 1));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b0000, 16'h0000, 1, 1));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b0000, 16'h0000, 0, 0));
        // Toggle mode with latch 0001.
        vecs.push_back(v(1, 4'h4, 8'h01, 4'b0000, 16'h0000, 0, 0));
        vecs.push_back(v(1, 4'h5, 8'h00, 4'b0000, 16'h0001, 0, 0));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1101, 16'h0001, 0, 1));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1101, 16'h0000, 0, 1));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1101, 16'h0001, 1, 0));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1101, 16'h0000, 0, 0));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1101, 16'h0001, 1, 1));
        // Start rising edge coincident with ufl: pb forced to 1, not toggled.
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b0101, 16'h0000, 0, 1));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1101, 16'h0001, 1, 1));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1101, 16'h0000, 0, 1));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1101, 16'h0001, 1, 0));
        // Pulse mode: pb follows ufl.
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h0000, 0, 0));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h0001, 1, 1));
        vecs.push_back(v(0, 4'h0, 8'h00, 4'b1001, 16'h0000, 0, 0));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 16'hFFFF, 1'b0, 1'b0);
        @(negedge clk);
        res_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_reset", 16'hFFFF, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            cyc(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].ctl, 1'b1);
            chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eu, vecs[i].ep);
        end

        // Without phi2_dn nothing advances, not even a high-byte write.
        cyc(1'b0, 4'h0, 8'h00, 4'b1001, 1'b0);
        cyc(1'b0, 4'h0, 8'h00, 4'b1001, 1'b0);
        cyc(1'b1, 4'h5, 8'h77, 4'b0000, 1'b0);
        chk_all("no_strobe", 16'h0000, 1'b0, 1'b0);

        // Low-byte write coinciding with underflow reloads the new byte: latch 0001 -> 0042.
        cyc(1'b1, 4'h4, 8'h42, 4'b0000, 1'b1);
        chk_all("wr_with_ufl", 16'h0042, 1'b1, 1'b1);

        // Asynchronous reset mid-count, checked before any clock edge.
        #2;
        res_n = 1'b0;
        #1;
        chk_all("async_reset", 16'hFFFF, 1'b0, 1'b0);
        @(negedge clk);
        res_n = 1'b1;

        // Count delay and latch were cleared by reset.
        cyc(1'b0, 4'h0, 8'h00, 4'b1001, 1'b1);
        chk("rst_cnt_dly", value, 16'hFFFF);
        cyc(1'b0, 4'h0, 8'h00, 4'b1001, 1'b1);
        chk("rst_count1", value, 16'hFFFE);
        cyc(1'b0, 4'h0, 8'h00, 4'b1010, 1'b1);
        chk("rst_latch", value, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
